lt16_soc_top: RTL and testbench

Minimal SoC top for the warm-up bring-up platform. It contains three parts:
- an internal reset synchronizer;
- a fixed-function bus master (LED sequencer) that periodically issues memory-mapped writes;
- a single LED peripheral register driving the 8 board LEDs.

It sits at the chip top, fed by the board clock and reset, and serves as the first smoke test of the SoC bus/peripheral path.

---
 rtl/lt16_soc_top.sv | 104 ++++++++++
 tb/tb_lt16_soc_top.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lt16_soc_top.sv
// ============================================================================
// Module   : lt16_soc_top
// Purpose  : Bring-up SoC top: reset synchronizer, LED sequencer bus master,
//            and an LED peripheral register. Optional macro: LED_WALK_EN
//            (walking-one pattern instead of binary up-count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lt16_soc_top #(
    parameter int          PRESCALE = 100,
    parameter logic [15:0] LED_ADDR = 16'hF000
) (
    input  logic       clk_sys,
    input  logic       rst,
    output logic [7:0] led
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_WRITE   = 1'b1;
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
`ifdef LED_WALK_EN
    localparam logic [7:0]  NEXT_RST   = 8'h01;
`else
    localparam logic [7:0]  NEXT_RST   = 8'h00;
`endif

    logic [1:0]  rst_sync_q;
    logic        rst_s_n;

    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic        tick;

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [7:0]  next_q;
    logic [7:0]  next_d;

    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;

    logic [7:0]  led_q;
    logic [7:0]  led_d;

    // Async assert, release after two clean edges with rst high.
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_s_n = rst_sync_q[1];

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? 16'h0000 : presc_q + 16'd1;

    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        if (state_q == ST_IDLE) begin
            if (tick) begin
                state_d = ST_WRITE;
`ifndef LED_WALK_EN
                next_d  = next_q + 8'd1;
`endif
            end
        end else begin
            state_d = ST_IDLE;
`ifdef LED_WALK_EN
            // Rotate after the write so the very first value written is 8'h01.
            next_d  = {next_q[6:0], next_q[7]};
`endif
        end
    end

    assign bus_we    = (state_q == ST_WRITE);
    assign bus_addr  = bus_we ? LED_ADDR : 16'h0000;
    assign bus_wdata = bus_we ? next_q : 8'h00;

    assign led_d = (bus_we && (bus_addr == LED_ADDR)) ? bus_wdata : led_q;

    always_ff @(posedge clk_sys or negedge rst_s_n) begin
        if (!rst_s_n) begin
            presc_q <= 16'h0000;
            state_q <= ST_IDLE;
            next_q  <= NEXT_RST;
            led_q   <= 8'h00;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
            next_q  <= next_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_lt16_soc_top.sv
// ============================================================================
// Module   : tb_lt16_soc_top
// Purpose  : Self-checking bench for lt16_soc_top (two instances: PRESCALE=100
//            at the default address, PRESCALE=4 at LED_ADDR=16'h1234).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lt16_soc_top;

    typedef struct {
        int         exp_edge;
        logic [7:0] val;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] led_a;
    logic [7:0] led_b;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ecnt        = 0;
    exp_t sb_q[$];

    lt16_soc_top #(.PRESCALE(100)) dut_a (
        .clk_sys (clk_sys),
        .rst     (rst),
        .led     (led_a)
    );

    lt16_soc_top #(.PRESCALE(4), .LED_ADDR(16'h1234)) dut_b (
        .clk_sys (clk_sys),
        .rst     (rst),
        .led     (led_b)
    );

    always #5 clk_sys = ~clk_sys;

    // Edges seen with rst high; the second one is the synchronous release edge.
    always @(posedge clk_sys or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    function automatic logic [7:0] seq_val(input int n);
`ifdef LED_WALK_EN
        if (n == 0) return 8'h00;
        return 8'h01 << ((n - 1) % 8);
`else
        return n[7:0];
`endif
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs until edge ncyc after sync release; led_b checked via scoreboard,
    // led_a spot-checked around each of its update edges.
    task automatic run_phase(input int ncyc);
        int         idx;
        int         iter;
        logic [7:0] prev_b;
        exp_t       e;
        sb_q.delete();
        for (int k = 1; 4 * k + 1 <= ncyc; k++) sb_q.push_back('{4 * k + 1, seq_val(k)});
        prev_b = 8'h00;
        iter   = 0;
        idx    = -2;
        while (idx < ncyc && iter < ncyc + 20) begin
            @(negedge clk_sys);
            iter++;
            idx = ecnt - 2;
            if (idx == 0) check8("led_a_at_release", led_a, 8'h00);
            if (idx >= 100 && (idx % 100 == 0 || idx % 100 == 1))
                check8("led_a_seq", led_a, seq_val(idx >= 101 ? (idx - 1) / 100 : 0));
            if (led_b !== prev_b) begin
                if (sb_q.size() == 0) begin
                    check8("led_b_unexpected", led_b, prev_b);
                end else begin
                    e = sb_q.pop_front();
                    check8("led_b_val", led_b, e.val);
                    check_int("led_b_edge", idx, e.exp_edge);
                end
                prev_b = led_b;
            end
        end
        check_int("phase_end_edge", idx, ncyc);
        check_int("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #3;
        check8("reset_a", led_a, 8'h00);
        check8("reset_b", led_b, 8'h00);
        #9 rst = 1'b1;                      // 2 ns before the edge at 15 ns

        // Ends right after edge 4100, where both instances sit in WRITE.
        run_phase(4100);

        rst = 1'b0;
        #1;
        check8("async_clr_a", led_a, 8'h00);
        check8("async_clr_b", led_b, 8'h00);
        #2 rst = 1'b1;                      // again 2 ns before an edge

        run_phase(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
